// File: rtl/regfile_sb.sv
// regfile_sb: architectural register file (x0..x31) with an in-flight-write
// scoreboard.
//
// The register file takes writes from the MEM/WB write-back port on the clock
// edge. It returns operands to ID combinationally, and a write-back that lands
// in the same cycle is forwarded straight to the readers. Each register keeps a
// small counter of issued-but-not-written-back producers. ID stalls while any
// operand it reads still has a producer in flight.
//
// Ports
//   clk_in, rst_in         clock; synchronous active-high reset
//   rdy_in                 global ready; 0 freezes all state (reads stay live)
//   we_in/waddr_in/wdata_in  write-back port (also retires one scoreboard entry)
//   re1_in/raddr1_in -> rdata1_out   read port 1 (combinational)
//   re2_in/raddr2_in -> rdata2_out   read port 2 (combinational)
//   mark_in/mark_addr_in   ID issued an instruction that will write rd
//   stall_req_out          some enabled operand is still awaiting write-back
//   sb_err_out             sticky counter over/underflow flag

// One architectural register plus its outstanding-writer counter.
module regfile_sb_slot #(
  parameter int DW   = 32,
  parameter int CNTW = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            wr_in,     // write-back targets this register
  input  logic            mk_in,     // ID marks this register as pending
  input  logic [DW-1:0]   wdata_in,
  output logic [DW-1:0]   data_out,
  output logic [CNTW-1:0] cnt_out,
  output logic            err_out    // this cycle's update over/underflowed
);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [DW-1:0]   data_d, data_q;
  logic [CNTW-1:0] cnt_d, cnt_q;

  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_out = 1'b0;
    if (rdy_in) begin
      if (wr_in) data_d = wdata_in;
      // A mark and a retire on the same register cancel out.
      if (mk_in && !wr_in) begin
        if (cnt_q == CNT_MAX) err_out = 1'b1;
        else                  cnt_d   = cnt_q + 1'b1;
      end else if (wr_in && !mk_in) begin
        if (cnt_q == '0) err_out = 1'b1;
        else             cnt_d   = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_out = data_q;
  assign cnt_out  = cnt_q;
endmodule

module regfile_sb #(
  parameter int NREG = 32,
  parameter int CNTW = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    we_in,
  input  logic [$clog2(NREG)-1:0] waddr_in,
  input  logic [31:0]             wdata_in,
  input  logic                    re1_in,
  input  logic [$clog2(NREG)-1:0] raddr1_in,
  output logic [31:0]             rdata1_out,
  input  logic                    re2_in,
  input  logic [$clog2(NREG)-1:0] raddr2_in,
  output logic [31:0]             rdata2_out,
  input  logic                    mark_in,
  input  logic [$clog2(NREG)-1:0] mark_addr_in,
  output logic                    stall_req_out,
  output logic                    sb_err_out
);
  localparam int AW = $clog2(NREG);

  logic [NREG-1:0][31:0]     regs;
  logic [NREG-1:0][CNTW-1:0] cnt;
  logic [NREG-1:0]           wr_vec, mk_vec, err_vec;

  // x0 is not stored: it reads as zero and never has a pending producer.
  assign regs[0]    = '0;
  assign cnt[0]     = '0;
  assign wr_vec[0]  = 1'b0;
  assign mk_vec[0]  = 1'b0;
  assign err_vec[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_slot
    assign wr_vec[i] = we_in   && (waddr_in     == AW'(i));
    assign mk_vec[i] = mark_in && (mark_addr_in == AW'(i));

    regfile_sb_slot #(.DW(32), .CNTW(CNTW)) u_slot (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .wr_in    (wr_vec[i]),
      .mk_in    (mk_vec[i]),
      .wdata_in (wdata_in),
      .data_out (regs[i]),
      .cnt_out  (cnt[i]),
      .err_out  (err_vec[i])
    );
  end

  // Sticky error flag. The slots already gate their error pulses with rdy_in.
  logic sb_err_d, sb_err_q;

  always_comb sb_err_d = sb_err_q | (|err_vec);

  always_ff @(posedge clk_in) begin
    if (rst_in) sb_err_q <= 1'b0;
    else        sb_err_q <= sb_err_d;
  end

  assign sb_err_out = sb_err_q;

  // Read ports with same-cycle write-back bypass. x0 never matches because the
  // address==0 case is forced to zero first.
  logic hit1, hit2, hz1, hz2;

  assign hit1 = we_in && (waddr_in == raddr1_in);
  assign hit2 = we_in && (waddr_in == raddr2_in);

  always_comb begin
    rdata1_out = '0;
    rdata2_out = '0;
    if (!rst_in && re1_in && raddr1_in != '0)
      rdata1_out = hit1 ? wdata_in : regs[raddr1_in];
    if (!rst_in && re2_in && raddr2_in != '0)
      rdata2_out = hit2 ? wdata_in : regs[raddr2_in];
  end

  // A write-back retiring the last outstanding producer releases the stall in
  // the same cycle, because the bypass already supplies the operand.
  // Same-cycle marks are deliberately ignored: the marker is the reader.
  always_comb begin
    hz1 = re1_in && raddr1_in != '0 && cnt[raddr1_in] != '0 &&
          !(hit1 && cnt[raddr1_in] == CNTW'(1));
    hz2 = re2_in && raddr2_in != '0 && cnt[raddr2_in] != '0 &&
          !(hit2 && cnt[raddr2_in] == CNTW'(1));
    stall_req_out = !rst_in && (hz1 || hz2);
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Architectural register file (x0–x31) with an in-flight-write scoreboard, sitting at the end of the pipeline as the consumer of the MEM/WB write-back port and the source of operands for the ID stage. Writes land on the clock edge; reads are combinational with same-cycle write-back bypass. A per-register outstanding-writer counter lets the stall controller hold ID until every operand it needs has been written back.

## Interface
Parameters:
- NREG, 32, number of architectural registers; x0 hardwired zero
- CNTW, 2, scoreboard counter width; maximum 3 outstanding writers per register

Ports:
- clk_in  input  1  clock; all state updates on posedge
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  global ready; when 0, no state changes
- we_in  input  1  write-back enable from MEM/WB
- waddr_in  input  5  write-back register address
- wdata_in  input  32  write-back data
- re1_in  input  1  read port 1 enable (ID)
- raddr1_in  input  5  read port 1 address
- rdata1_out  output  32  read port 1 data, combinational
- re2_in  input  1  read port 2 enable
- raddr2_in  input  5  read port 2 address
- rdata2_out  output  32  read port 2 data, combinational
- mark_in  input  1  ID issues an instruction that will write rd
- mark_addr_in  input  5  that instruction's rd
- stall_req_out  output  1  ID operand not yet written back; to stall ctrl
- sb_err_out  output  1  sticky scoreboard over/underflow flag

## Operation
- Storage: 31 × 32-bit registers (x1–x31). x0 is never stored; reads of x0 return 0.
- Write: on posedge with rst_in=0, rdy_in=1, we_in=1, waddr_in≠0, reg[waddr_in] <= wdata_in. Writes to x0 are dropped silently.
- Read port n: if re_n=0 or raddr_n=0 -> 0. Else if we_in=1 and waddr_in=raddr_n (≠0) -> wdata_in (bypass). Else reg[raddr_n].
- Scoreboard: cnt[r], CNTW bits, r=1..31; cnt[0] constant 0. Per posedge with rdy_in=1:
  - inc = mark_in && mark_addr_in≠0; dec = we_in && waddr_in≠0.
  - Same address, inc and dec together -> cnt unchanged.
  - inc only: cnt<3 -> cnt+1; cnt=3 -> hold, set sb_err_out.
  - dec only: cnt>0 -> cnt−1; cnt=0 -> hold at 0, set sb_err_out.
  - Different addresses: each updated independently in the same cycle.
- Stall (combinational): hazard_n = re_n && raddr_n≠0 && cnt[raddr_n]≠0 && !(dec && waddr_in=raddr_n && cnt[raddr_n]=1). stall_req_out = hazard_1 | hazard_2.
- A mark in the current cycle does not affect the current cycle's stall_req_out (the marking instruction is the reader, not a prior producer).
- rdy_in=0: registers, counters and sb_err_out hold; reads, bypass and stall_req_out remain combinationally live.

## Timing
- Reset (posedge with rst_in=1, regardless of rdy_in): all registers 0, all counters 0, sb_err_out 0. While rst_in=1, rdata1_out=rdata2_out=0 and stall_req_out=0.
- Write-to-read latency: 0 cycles via bypass; value is stored from the following cycle.
- Mark-to-stall latency: 1 cycle (stall visible from the cycle after mark_in).
- Write-back resolving the last outstanding writer releases stall in the same cycle.
- sb_err_out is sticky until reset.
- Reset mid-operation discards all pending counts; the pipeline is flushed by the same reset.

## Test plan
- Reset then read: rst_in pulse, re1=re2=1, raddr1=5, raddr2=31 -> rdata 0/0, stall_req_out=0, sb_err_out=0.
- Write/bypass: we=1, waddr=7, wdata=0xDEADBEEF, re1=1, raddr1=7 same cycle -> rdata1=0xDEADBEEF. Next cycle, we=0 -> still 0xDEADBEEF.
- x0: we=1, waddr=0, wdata=0x1234; mark x0; read raddr1=0 -> rdata1=0, no stall, cnt unchanged, no error.
- Scoreboard stall: mark x3 at cycle 0; cycle 1 read x3 -> stall=1; cycle 2 write x3=0x55 with read x3 -> stall=0, rdata=0x55.
- Two producers: mark x4 at cycles 0 and 1; write x4=1 at cycle 3 -> stall still 1 (cnt 2->1); write x4=2 at cycle 4 -> stall 0, rdata 2. Mark and write x4 in the same cycle -> cnt unchanged.
- Errors/rdy: write x9 with cnt=0 -> sb_err_out=1 sticky. Four marks of x10 -> cnt saturates at 3, error set. rdy_in=0 with we=1 -> register and count unchanged.
